// File: rtl/riscv_pkg.sv
// Shared RISC-V defines: base opcodes, PC/instruction widths and the fetch entry type.
// The fetch unit and control_unit both take these from here.
package riscv_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_L      = 7'b0000011;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic opc_supported(input logic [6:0] opc);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_R, OPC_I, OPC_S, OPC_L, OPC_B_TYPE, OPC_JAL, OPC_JALR: ok = 1'b1;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small instruction FIFO between ROM return and the consumer; head is read straight
// from registered storage. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues sequential ROM reads, buffers returned words, handles
// redirects and stops fetching when the buffer head holds an unsupported opcode.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 11'h000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [7:0]         rom_addr,
    output logic               rom_rden,
    input  logic [INSTR_W-1:0] rom_q,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted
);

    fetch_entry_t                      head;
    fetch_entry_t                      wentry;
    logic                              buf_full;
    logic                              buf_empty;
    logic [$clog2(BUF_DEPTH+1)-1:0]    buf_count;
    logic                              push;
    logic                              pop;
    logic                              head_bad;
    logic [3:0]                        occ;
    logic [PC_W-1:0]                   fetch_pc_q;
    logic [PC_W-1:0]                   inflight_pc_q;
    logic                              inflight_q;
    logic                              halted_q;
    logic                              unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    assign head_bad    = !buf_empty && !opc_supported(head.instr[6:0]);
    assign instr_valid = !buf_empty && !head_bad;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign halted      = halted_q;

    assign pop    = instr_valid && instr_ready;
    // A read returning in a redirect cycle belongs to the old stream and is dropped.
    assign push   = inflight_q && !redirect_valid;
    assign wentry = '{instr: rom_q, pc: inflight_pc_q};

    // Occupancy after this cycle's pop, counting the read already on its way back.
    assign occ      = 4'(buf_count) + 4'(inflight_q) - 4'(pop);
    assign rom_rden = !rst && !halted_q && !(buf_full && !pop) && (occ < 4'(BUF_DEPTH));
    assign rom_addr = rst ? 8'h00 : fetch_pc_q[9:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            inflight_q <= rom_rden;
            if (rom_rden) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + PC_W'(4);
            end
            if (head_bad) halted_q <= 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed timing scenarios plus a randomized phase, all
// deliveries scored against a sequential-PC stream model over the bench's ROM image.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  rom_addr;
    logic        rom_rden;
    logic [31:0] rom_q;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [10:0] instr_pc;
    logic        halted;

    logic [31:0] rom [256];
    logic [6:0]  good_ops [7] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67};

    int n_chk  = 0;
    int n_pass = 0;

    ifetch_unit #(.RESET_PC(11'h000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_rden       (rom_rden),
        .rom_q          (rom_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM returns the addressed word after a strobe, garbage otherwise.
    always @(posedge clk) rom_q <= rom_rden ? rom[rom_addr] : $urandom;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic is_bad(input logic [31:0] w);
        logic b;
        b = 1'b1;
        for (int i = 0; i < 7; i++) if (w[6:0] == good_ops[i]) b = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] word(input int i);
        return 32'h0000_0013 + (32'(i) << 7);
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Stream model: each delivered instruction must be the next sequential PC of the
    // current stream, with the ROM word at that PC; a redirect restarts the stream.
    logic [10:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_instr;
    logic [10:0] prev_pc;
    int          gap;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_pc    = 11'h000;
            prev_hold = 1'b0;
            gap       = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_vld", instr_valid, 1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", instr_pc, prev_pc);
            end
            if (instr_valid) begin
                chk("sb_pc", instr_pc, exp_pc);
                chk("sb_instr", instr, rom[exp_pc[9:2]]);
                chk("sb_supported", is_bad(instr), 0);
            end
            if (halted) begin
                chk("halt_rden", rom_rden, 0);
                chk("halt_vld", instr_valid, 0);
                chk("halt_cause", is_bad(rom[exp_pc[9:2]]), 1);
            end
            if (redirect_valid) gap = 0;
            else if (!instr_valid && !halted) begin
                gap++;
                chk("live", gap > 3, 0);
            end else gap = 0;
            prev_hold  = instr_valid && !instr_ready && !redirect_valid;
            prev_instr = instr;
            prev_pc    = instr_pc;
            if (instr_valid && instr_ready) exp_pc = exp_pc + 11'd4;
            if (redirect_valid) exp_pc = {redirect_pc[10:2], 2'b00};
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rden"}, rom_rden, 0);
        chk({tag, "_vld"}, instr_valid, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_pc"}, instr_pc, 0);
        chk({tag, "_addr"}, rom_addr, 0);
    endtask

    initial begin
        logic        seen;
        logic [31:0] r;
        logic [6:0]  op;

        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 256; i++) rom[i] = word(i);

        // Reset release and steady streaming
        cyc(); cyc(); #1;
        chk_reset_outputs("rst");
        cyc(); rst = 1'b0; #1;
        chk("c1_rden", rom_rden, 1);
        chk("c1_addr", rom_addr, 0);
        cyc(); #1;
        chk("c2_vld", instr_valid, 0);
        cyc(); #1;
        chk("c3_vld", instr_valid, 1);
        chk("c3_pc", instr_pc, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            chk("stream_vld", instr_valid, 1);
            chk("stream_pc", instr_pc, 32'(4 * k));
        end

        // Consumer stall at 0x010
        cyc(); instr_ready = 1'b0; #1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin cyc(); #1; end
            chk("stall_pc", instr_pc, 32'h010);
            chk("stall_instr", instr, word(4));
            if (s > 0) chk("stall_rden", rom_rden, 0);
        end
        cyc(); instr_ready = 1'b1; #1;
        chk("resume_pc0", instr_pc, 32'h010);
        cyc(); #1;
        chk("resume_pc1", instr_pc, 32'h014);

        // Redirect with a full buffer
        cyc(); instr_ready = 1'b0;
        cyc();
        cyc(); redirect_valid = 1'b1; redirect_pc = 11'h046; #1;
        cyc(); redirect_valid = 1'b0; instr_ready = 1'b1; #1;
        chk("redir_r1_vld", instr_valid, 0);
        chk("redir_r1_rden", rom_rden, 1);
        chk("redir_r1_addr", rom_addr, 8'h11);
        cyc(); #1;
        chk("redir_r2_vld", instr_valid, 0);
        cyc(); #1;
        chk("redir_r3_vld", instr_valid, 1);
        chk("redir_r3_pc", instr_pc, 32'h044);

        // PC wrap, then run into an unsupported word at 0x00C
        cyc(); cyc();
        cyc(); redirect_valid = 1'b1; redirect_pc = 11'h7FE; rom[3] = 32'h0000_007F; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("wrap_addr0", rom_addr, 8'hFF);
        chk("wrap_rden0", rom_rden, 1);
        cyc(); #1;
        chk("wrap_addr1", rom_addr, 8'h00);
        cyc(); #1;
        chk("wrap_pc0", instr_pc, 32'h7FC);
        cyc(); #1;
        chk("wrap_pc1", instr_pc, 32'h000);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc(); #1;
            seen = halted;
        end
        chk("halt_seen", seen, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            chk("halt_sticky", halted, 1);
            chk("halt_no_rd", rom_rden, 0);
        end
        cyc(); redirect_valid = 1'b1; redirect_pc = 11'h000; #1;
        cyc(); redirect_valid = 1'b0; rom[3] = word(3); #1;
        chk("unhalt", halted, 0);
        chk("unhalt_rden", rom_rden, 1);
        cyc(); cyc(); #1;
        chk("unhalt_vld", instr_valid, 1);
        chk("unhalt_pc", instr_pc, 0);

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 6; i++) cyc();
        cyc(); rst = 1'b1; #1;
        chk_reset_outputs("midrst");
        cyc();
        cyc(); rst = 1'b0; #1;
        chk("midrst_c1_rden", rom_rden, 1);
        cyc(); #1;
        chk("midrst_c2_vld", instr_valid, 0);
        cyc(); #1;
        chk("midrst_c3_vld", instr_valid, 1);
        chk("midrst_c3_pc", instr_pc, 0);

        // Randomized phase over a random ROM image with occasional bad opcodes
        cyc(); rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            r  = $urandom;
            op = ($urandom_range(0, 31) == 0) ? 7'h37 : good_ops[$urandom_range(0, 6)];
            rom[i] = {r[31:7], op};
        end
        cyc(); rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 11'($urandom);
        end
        cyc(); redirect_valid = 1'b0; instr_ready = 1'b1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
